// File: rtl/fifo_1_mem.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_1_mem
//  Purpose  : DEPTH x DATA_WIDTH register array for fifo_1. One synchronous
//             write port and one synchronous read port whose output register
//             is cleared by reset and holds when no read is enabled.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_wr_en/addr/data - write port (mem[addr] <= data)
//             i_rd_en/addr      - read port enable and address
//             o_rd_data         - registered read word
//  Revision : 1.0  initial release
// ============================================================================
module fifo_1_mem #(
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/fifo_1.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_1
//  Purpose  : Single-clock synchronous FIFO with registered read port and
//             full/empty flags. Depth = 2**FIFO_PTR_WIDTH.
//  Ports    : clk, rst    - clock (rising edge), synchronous active-high reset
//             write, read - request strobes sampled at rising clk
//             write_data  - word stored on an accepted write
//             read_data   - registered word, updated by accepted reads
//             empty, full - occupancy flags from the registered pointers
//  Revision : 1.0  initial release
// ============================================================================
module fifo_1 #(
  parameter int FIFO_PTR_WIDTH  = 3,
  parameter int FIFO_DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write,
  input  logic                       read,
  input  logic [FIFO_DATA_WIDTH-1:0] write_data,
  output logic [FIFO_DATA_WIDTH-1:0] read_data,
  output logic                       empty,
  output logic                       full
);

  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam logic [FIFO_PTR_WIDTH:0] c_ptr_one = {{FIFO_PTR_WIDTH{1'b0}}, 1'b1};

  // One extra pointer bit distinguishes full from empty when low bits match.
  logic [FIFO_PTR_WIDTH:0] r_wr_ptr;
  logic [FIFO_PTR_WIDTH:0] r_rd_ptr;
  logic                    w_wr_en;
  logic                    w_rd_en;
  logic                    w_empty;
  logic                    w_full;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[FIFO_PTR_WIDTH] != r_rd_ptr[FIFO_PTR_WIDTH]) &&
                   (r_wr_ptr[FIFO_PTR_WIDTH-1:0] == r_rd_ptr[FIFO_PTR_WIDTH-1:0]);

  // Each side is qualified against the pre-edge flags independently, so a
  // read+write on empty only writes and on full only reads.
  assign w_wr_en = write && !w_full;
  assign w_rd_en = read  && !w_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
    end
  end

  // Write is suppressed during reset so a reset cycle has no side effects
  // on storage that a later read could observe as stale-but-valid data.
  fifo_1_mem #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (FIFO_PTR_WIDTH),
    .DATA_WIDTH (FIFO_DATA_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_wr_en && !rst),
    .i_wr_addr (r_wr_ptr[FIFO_PTR_WIDTH-1:0]),
    .i_wr_data (write_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_ptr[FIFO_PTR_WIDTH-1:0]),
    .o_rd_data (read_data)
  );

  assign empty = w_empty;
  assign full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_fifo_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_1
//  Purpose  : Self-checking bench for fifo_1 (8 x 8 default). A driver issues
//             directed vectors and keeps a reference queue; expected read
//             words go into a scoreboard queue that a negedge monitor drains
//             and compares against read_data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_1;

  logic       clk;
  logic       rst;
  logic       write;
  logic       read;
  logic [7:0] write_data;
  logic [7:0] read_data;
  logic       empty;
  logic       full;

  int vectors;
  int miscompares;

  logic [7:0] model[$];   // reference contents, oldest first
  logic [7:0] exp_q[$];   // scoreboard: words due on read_data
  logic [7:0] exp_rd;     // value read_data must currently show
  bit         mon_en;

  fifo_1 #(
    .FIFO_PTR_WIDTH  (3),
    .FIFO_DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .write      (write),
    .read       (read),
    .write_data (write_data),
    .read_data  (read_data),
    .empty      (empty),
    .full       (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: after every rising edge, pick up any newly due word and check
  // that read_data shows it (or still holds the previous one).
  always @(negedge clk) begin
    if (mon_en) begin
      if (exp_q.size() > 0) exp_rd = exp_q.pop_front();
      vectors++;
      if (read_data !== exp_rd) begin
        miscompares++;
        $display("FAIL read_data: got %02h expected %02h at %0t", read_data, exp_rd, $time);
      end
    end
  end

  task automatic check_flags(string tag);
    logic e_exp;
    logic f_exp;
    e_exp = (model.size() == 0);
    f_exp = (model.size() == 8);
    vectors++;
    if (empty !== e_exp || full !== f_exp) begin
      miscompares++;
      $display("FAIL flags(%s): got empty=%b full=%b expected empty=%b full=%b",
               tag, empty, full, e_exp, f_exp);
    end
  endtask

  // One clock of stimulus; reference model evaluated on pre-edge occupancy.
  task automatic step(bit w, bit r, logic [7:0] d, string tag);
    bit         wa;
    bit         ra;
    logic [7:0] due;
    write      = w;
    read       = r;
    write_data = d;
    wa = w && (model.size() < 8);
    ra = r && (model.size() > 0);
    if (ra) due = model.pop_front();
    if (wa) model.push_back(d);
    @(posedge clk);
    if (ra) exp_q.push_back(due);
    #1;
    write = 1'b0;
    read  = 1'b0;
    check_flags(tag);
  endtask

  // Reset with both requests active: reset must win.
  task automatic do_reset();
    rst   = 1'b1;
    write = 1'b1;
    read  = 1'b1;
    write_data = 8'hEE;
    @(posedge clk);
    model.delete();
    exp_q.delete();
    exp_rd = 8'h00;
    #1;
    rst   = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    check_flags("reset");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    mon_en      = 1'b0;
    exp_rd      = 8'h00;
    rst = 1'b1; write = 1'b0; read = 1'b0; write_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    do_reset();

    // 1. Idle, then read on empty
    step(0, 0, 8'h00, "idle");
    step(0, 1, 8'h00, "rd_empty");
    step(0, 0, 8'h00, "idle2");

    // 2. Six writes with idle gaps, then six reads
    for (int i = 1; i <= 6; i++) begin
      step(1, 0, 8'(i * 8'h11), "wr6");
      step(0, 0, 8'h00, "gap");
    end
    for (int i = 0; i < 6; i++) step(0, 1, 8'h00, "rd6");
    step(0, 0, 8'h00, "drained6");

    // 3. Fill to full, drop a ninth write, drain
    for (int i = 1; i <= 8; i++) step(1, 0, 8'(i), "fill");
    step(1, 0, 8'hFF, "wr_full");
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, "drain8");
    step(0, 0, 8'h00, "drained8");

    // 4. Three rounds of 5 in / 5 out, wrapping the pointers
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) step(1, 0, 8'((r + 2) * 16 + i), "wrap_wr");
      for (int i = 0; i < 5; i++) step(0, 1, 8'h00, "wrap_rd");
      step(0, 0, 8'h00, "wrap_end");
    end

    // 5a. Simultaneous read/write with 3 stored
    for (int i = 0; i < 3; i++) step(1, 0, 8'hC0 + 8'(i), "sim3_fill");
    step(1, 1, 8'hC3, "sim3_rw");
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00, "sim3_drain");
    step(0, 0, 8'h00, "sim3_end");
    // 5b. Simultaneous on empty: write only, no bypass
    step(1, 1, 8'h5A, "sim_empty");
    step(0, 0, 8'h00, "sim_empty2");
    step(0, 1, 8'h00, "sim_empty_rd");
    // 5c. Simultaneous on full: read only
    for (int i = 0; i < 8; i++) step(1, 0, 8'h80 + 8'(i), "sim_full_fill");
    step(1, 1, 8'h99, "sim_full");
    for (int i = 0; i < 7; i++) step(0, 1, 8'h00, "sim_full_drain");
    step(0, 0, 8'h00, "sim_full_end");

    // 6. Reset mid-stream with 4 stored
    for (int i = 0; i < 4; i++) step(1, 0, 8'hD0 + 8'(i), "pre_rst");
    step(0, 1, 8'h00, "pre_rst_rd");
    do_reset();
    step(0, 0, 8'h00, "post_rst");
    step(1, 0, 8'hA5, "post_wr");
    step(0, 1, 8'h00, "post_rd");
    step(0, 0, 8'h00, "post_end");

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard: got %0d undelivered words expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
